// File: rtl/reg_file_mp.sv
// ---------------------------------------------------------------------------
// reg_file_mp
// Multi-port integer register file for the pipelined core.
//  - NRD combinational read ports, NWR write ports (highest port wins on a
//    same-address collision), optional same-cycle write-to-read forwarding.
//  - Pending-write scoreboard so the issue stage can see RAW hazards.
//  - After reset a hardware sequence zeroes every entry, one per cycle,
//    before ready goes high.
// Ports:
//  clk      in   rising-edge clock
//  rst_n    in   asynchronous active-low reset
//  ready    out  clear sequence done, file usable
//  rd_addr  in   NRD*AW    read address, port i at [i*AW +: AW]
//  rd_data  out  NRD*WIDTH read data,    port i at [i*WIDTH +: WIDTH]
//  rd_busy  out  NRD       pending write on that address, not forwarded now
//  wr_en    in   NWR       write enable per port
//  wr_addr  in   NWR*AW    write address per port
//  wr_data  in   NWR*WIDTH write data per port
//  sb_set   in   mark sb_addr as having an outstanding producer
//  sb_addr  in   AW        scoreboard address
// ---------------------------------------------------------------------------
module reg_file_mp #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 ready,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*WIDTH-1:0] rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*AW-1:0]    wr_addr,
  input  logic [NWR*WIDTH-1:0] wr_data,
  input  logic                 sb_set,
  input  logic [AW-1:0]        sb_addr
);

  localparam logic [AW:0]   DEPTH_EXT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     clr_cnt_q, clr_cnt_d;
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];

  // An address is "live" when it maps to a real, writable register.
  // Dead addresses (hardwired x0, out of range) drop writes and read as 0.
  function automatic logic addr_live(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_EXT) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign ready = (state_q == S_READY);

  // Clear sequencer: one entry per cycle, READY after the last entry.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == S_CLEAR) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == LAST_IDX) begin
        state_d   = S_READY;
        clr_cnt_d = '0;
      end
    end
  end

  // Scoreboard: writes retire producers, sb_set applied last so that a new
  // producer issued in the same cycle keeps the bit set.
  always_comb begin
    pend_d = pend_q;
    if (state_q == S_READY) begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && addr_live(wr_addr[j*AW +: AW]))
          pend_d[wr_addr[j*AW +: AW]] = 1'b0;
      end
      if (sb_set && addr_live(sb_addr))
        pend_d[sb_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_CLEAR;
      clr_cnt_q <= '0;
      pend_q    <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      pend_q    <= pend_d;
    end
  end

  // Storage is never reset directly; the clear sequence zeroes it.
  // Ascending port order makes the highest port the last assignment.
  always_ff @(posedge clk) begin
    if (state_q == S_CLEAR) begin
      mem_q[clr_cnt_q] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && addr_live(wr_addr[j*AW +: AW]))
          mem_q[wr_addr[j*AW +: AW]] <= wr_data[j*WIDTH +: WIDTH];
      end
    end
  end

  logic [AW-1:0] ra;
  logic          hit;

  // Read ports; the forwarding scan runs in ascending order so the highest
  // matching write port supplies the data.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    hit     = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      ra  = rd_addr[i*AW +: AW];
      hit = 1'b0;
      if ((state_q == S_READY) && addr_live(ra)) begin
        rd_data[i*WIDTH +: WIDTH] = mem_q[ra];
        if (BYPASS != 0) begin
          for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && (wr_addr[j*AW +: AW] == ra)) begin
              rd_data[i*WIDTH +: WIDTH] = wr_data[j*WIDTH +: WIDTH];
              hit = 1'b1;
            end
          end
        end
        rd_busy[i] = pend_q[ra] && !hit;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
module tb_reg_file_mp;

  localparam int W  = 64;
  localparam int D  = 32;
  localparam int AW = 5;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [2*AW-1:0] rd_addr = '0;
  logic [1:0]     wr_en = '0;
  logic [2*AW-1:0] wr_addr = '0;
  logic [2*W-1:0] wr_data = '0;
  logic           sb_set = 1'b0;
  logic [AW-1:0]  sb_addr = '0;

  logic           rdy_a, rdy_b;
  logic [2*W-1:0] rdd_a, rdd_b;
  logic [1:0]     rdb_a, rdb_b;

  int checks = 0;
  int failures = 0;

  // Config 0: BYPASS=1, ZERO_REG=1.  Config 1: BYPASS=0, ZERO_REG=0.
  reg_file_mp #(.WIDTH(W), .DEPTH(D), .NRD(2), .NWR(2), .BYPASS(1), .ZERO_REG(1)) u_a (
    .clk(clk), .rst_n(rst_n), .ready(rdy_a), .rd_addr(rd_addr), .rd_data(rdd_a),
    .rd_busy(rdb_a), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .sb_set(sb_set), .sb_addr(sb_addr));

  reg_file_mp #(.WIDTH(W), .DEPTH(D), .NRD(2), .NWR(2), .BYPASS(0), .ZERO_REG(0)) u_b (
    .clk(clk), .rst_n(rst_n), .ready(rdy_b), .rd_addr(rd_addr), .rd_data(rdd_b),
    .rd_busy(rdb_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .sb_set(sb_set), .sb_addr(sb_addr));

  always #5 clk = ~clk;

  // Reference model: plain arrays per configuration.
  logic [W-1:0] mm [2][D];
  bit           mp [2][D];
  bit           byp [2] = '{1'b1, 1'b0};
  bit           zr  [2] = '{1'b1, 1'b0};
  int           edges = 0;
  bit           mready = 1'b0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void exp_rd(input int c, input int a, output logic [W-1:0] d, output logic b);
    bit hit;
    d = '0; b = 1'b0; hit = 1'b0;
    if (!mready) return;
    if (zr[c] && a == 0) return;
    d = mm[c][a];
    if (byp[c])
      for (int j = 0; j < 2; j++)
        if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == a) begin
          d = wr_data[j*W +: W];
          hit = 1'b1;
        end
    b = mp[c][a] && !hit;
  endfunction

  task automatic check_cfg(input int c, input logic rdy, input logic [2*W-1:0] rdd, input logic [1:0] rdb);
    logic [W-1:0] d;
    logic b;
    chk($sformatf("c%0d_ready", c), {63'd0, rdy}, {63'd0, mready});
    for (int i = 0; i < 2; i++) begin
      exp_rd(c, int'(rd_addr[i*AW +: AW]), d, b);
      chk($sformatf("c%0d_rd%0d_data", c, i), rdd[i*W +: W], d);
      chk($sformatf("c%0d_rd%0d_busy", c, i), {63'd0, rdb[i]}, {63'd0, b});
    end
  endtask

  task automatic model_reset();
    edges = 0;
    mready = 1'b0;
    for (int c = 0; c < 2; c++)
      for (int a = 0; a < D; a++) mp[c][a] = 1'b0;
  endtask

  task automatic model_edge();
    int wa;
    if (!rst_n) return;
    if (!mready) begin
      edges++;
      if (edges == D) begin
        mready = 1'b1;
        for (int c = 0; c < 2; c++)
          for (int a = 0; a < D; a++) mm[c][a] = '0;
      end
      return;
    end
    for (int c = 0; c < 2; c++) begin
      for (int j = 0; j < 2; j++) begin
        wa = int'(wr_addr[j*AW +: AW]);
        if (wr_en[j] && !(zr[c] && wa == 0)) begin
          mm[c][wa] = wr_data[j*W +: W];
          mp[c][wa] = 1'b0;
        end
      end
      if (sb_set && !(zr[c] && sb_addr == 0)) mp[c][sb_addr] = 1'b1;
    end
  endtask

  task automatic cyc();
    #1;
    check_cfg(0, rdy_a, rdd_a, rdb_a);
    check_cfg(1, rdy_b, rdd_b, rdb_b);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0; sb_set = 1'b0; sb_addr = '0;
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr = {AW'(a1), AW'(a0)};
  endtask

  task automatic set_wr(input int j, input int a, input logic [W-1:0] d);
    wr_en[j] = 1'b1;
    wr_addr[j*AW +: AW] = AW'(a);
    wr_data[j*W +: W] = d;
  endtask

  task automatic rand_inputs();
    for (int j = 0; j < 2; j++) begin
      wr_en[j] = 1'($urandom);
      wr_addr[j*AW +: AW] = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 31));
      wr_data[j*W +: W] = {$urandom, $urandom};
    end
    sb_set = ($urandom_range(0, 2) == 0);
    sb_addr = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 31));
    set_rd(($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, 31), $urandom_range(0, 7));
  endtask

  initial begin
    model_reset();
    @(negedge clk);

    // Reset state, then release and count the clear sequence.
    cyc(); cyc();
    rst_n = 1'b1;
    for (int k = 0; k < D; k++) cyc();
    #1;
    chk("ready_a_after_clear", {63'd0, rdy_a}, 64'd1);
    for (int k = 0; k < D / 2; k++) begin
      set_rd(2 * k, 2 * k + 1);
      cyc();
    end

    // Pre-fill x5, then reset mid-clear at clear cycle 10.
    idle(); set_wr(0, 5, 64'hDEAD_BEEF); cyc();
    idle(); set_rd(5, 5);
    #1; chk("x5_prefill", rdd_a[W-1:0], 64'hDEAD_BEEF);
    cyc();
    rst_n = 1'b0; model_reset();
    cyc(); cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin rand_inputs(); cyc(); end
    rst_n = 1'b0; model_reset();
    idle(); cyc();
    rst_n = 1'b1;
    for (int k = 0; k < D; k++) begin rand_inputs(); cyc(); end
    idle(); set_rd(5, 5);
    #1; chk("x5_after_reset", rdd_a[W-1:0], 64'd0);
    cyc();

    // Two writes to x7 in one cycle, highest port wins, forwarded.
    idle(); set_wr(0, 7, 64'h11); set_wr(1, 7, 64'h22); set_rd(7, 0);
    #1; chk("x7_bypass", rdd_a[W-1:0], 64'h22);
    cyc();
    idle(); set_rd(7, 7);
    #1; chk("x7_stored", rdd_b[W-1:0], 64'h22);
    cyc();

    // No-bypass config returns the old value in the write cycle.
    idle(); set_wr(0, 3, 64'hAA); set_rd(3, 3);
    #1; chk("x3_nobypass", rdd_b[W-1:0], 64'h0);
    cyc();
    idle();
    #1; chk("x3_next", rdd_b[W-1:0], 64'hAA);
    cyc();

    // x0 hardwired only with ZERO_REG=1.
    idle(); set_wr(1, 0, 64'hFF); set_rd(0, 0); cyc();
    idle();
    #1; chk("x0_zero_reg", rdd_a[W-1:0], 64'h0);
    chk("x0_plain_reg", rdd_b[W-1:0], 64'hFF);
    cyc();

    // Scoreboard set, clear by write, and set-wins collision.
    idle(); sb_set = 1'b1; sb_addr = 5'd9; set_rd(9, 9); cyc();
    idle();
    #1; chk("x9_busy", {63'd0, rdb_a[0]}, 64'd1);
    cyc();
    set_wr(0, 9, 64'h99);
    #1; chk("x9_fwd_not_busy", {63'd0, rdb_a[0]}, 64'd0);
    chk("x9_nofwd_busy", {63'd0, rdb_b[0]}, 64'd1);
    cyc();
    idle();
    #1; chk("x9_cleared", {63'd0, rdb_a[0]}, 64'd0);
    cyc();
    set_wr(1, 9, 64'h123); sb_set = 1'b1; sb_addr = 5'd9; cyc();
    idle();
    #1; chk("x9_set_wins", {63'd0, rdb_b[0]}, 64'd1);
    cyc();

    // Randomized traffic with one mid-run reset.
    for (int k = 0; k < 400; k++) begin
      if (k == 200) begin
        rst_n = 1'b0; model_reset();
        rand_inputs(); cyc();
        rst_n = 1'b1;
      end
      rand_inputs();
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
